sram_controller: RTL

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/sram_controller.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/sram_controller.sv
// sram_controller: bridges a 32-bit load/store stage onto a 16-bit asynchronous
// SRAM. Each access runs IDLE -> LO -> HI -> WAIT(3) -> DONE, so ready rises in
// the seventh cycle after the request is first seen in IDLE.
//
// Ports
//   clk, rst             clock; asynchronous active-low reset
//   wr_en, rd_en         store / load request (store wins when both are set)
//   address, writeData   byte address and store value, latched when the access starts
//   readData             load result, held until the next load capture
//   ready                combinational: access complete, or idle with no request
//   SRAM_DQ              16-bit bidirectional SRAM data bus
//   SRAM_ADDR            halfword address ({word index, half select})
//   SRAM_WE_N            write strobe, low during write LO/HI
//   SRAM_CE_N/OE_N/UB_N/LB_N  tied active
module sram_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  localparam int unsigned IDX_W  = 17;
  localparam int unsigned HALF_W = 16;
  localparam int unsigned CNT_W  = 2;
  localparam logic [31:0]      BASE_ADDR = 32'd1024;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(2);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LO,
    ST_HI,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [HALF_W-1:0]   wdata_hi_q, wdata_hi_d;
  logic                is_wr_q, is_wr_d;
  logic [31:0]         rdata_d;
  logic [17:0]         sram_addr_d;
  logic                we_n_d;
  logic                dq_oe_q, dq_oe_d;
  logic [HALF_W-1:0]   dq_out_q, dq_out_d;

  // Data bus is only driven by us during the two write strobe cycles.
  assign SRAM_DQ = dq_oe_q ? dq_out_q : {HALF_W{1'bz}};

  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

  // Completion flag; idle counts as ready only when nothing is requested.
  assign ready = (state_q == ST_DONE) ||
                 ((state_q == ST_IDLE) && !wr_en && !rd_en);

  // Next state plus next values of the registered SRAM-side outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    wdata_hi_d  = wdata_hi_q;
    is_wr_d     = is_wr_q;
    rdata_d     = readData;
    sram_addr_d = '0;
    we_n_d      = 1'b1;
    dq_oe_d     = 1'b0;
    dq_out_d    = '0;

    case (state_q)
      ST_IDLE: begin
        if (wr_en || rd_en) begin
          state_d     = ST_LO;
          // Unsigned wrap keeps out-of-range addresses inside the 2^17-word array.
          idx_d       = IDX_W'((address - BASE_ADDR) >> 2);
          wdata_hi_d  = writeData[31:16];
          is_wr_d     = wr_en;
          sram_addr_d = {idx_d, 1'b0};
          we_n_d      = ~wr_en;
          dq_oe_d     = wr_en;
          dq_out_d    = writeData[15:0];
        end
      end
      ST_LO: begin
        state_d = ST_HI;
        if (!is_wr_q) rdata_d[15:0] = SRAM_DQ;
        sram_addr_d = {idx_q, 1'b1};
        we_n_d      = ~is_wr_q;
        dq_oe_d     = is_wr_q;
        dq_out_d    = wdata_hi_q;
      end
      ST_HI: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
        if (!is_wr_q) rdata_d[31:16] = SRAM_DQ;
      end
      ST_WAIT: begin
        if (cnt_q == WAIT_LAST) state_d = ST_DONE;
        else                    cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      wdata_hi_q <= '0;
      is_wr_q    <= 1'b0;
      readData   <= '0;
      SRAM_ADDR  <= '0;
      SRAM_WE_N  <= 1'b1;
      dq_oe_q    <= 1'b0;
      dq_out_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      wdata_hi_q <= wdata_hi_d;
      is_wr_q    <= is_wr_d;
      readData   <= rdata_d;
      SRAM_ADDR  <= sram_addr_d;
      SRAM_WE_N  <= we_n_d;
      dq_oe_q    <= dq_oe_d;
      dq_out_q   <= dq_out_d;
    end
  end

endmodule
